// File: rtl/intro_fade_ctrl.sv
// Intro screen brightness sequencer: fade in, hold, fade out, done.
// Optional skip input enabled by defining INTRO_FADE_SKIP_EN.
module intro_fade_ctrl #(
    parameter int STEP_FRAMES = 4,
    parameter int HOLD_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       video_on,
    input  logic [3:0] pal_red,
    input  logic [3:0] pal_green,
    input  logic [3:0] pal_blue,
`ifdef INTRO_FADE_SKIP_EN
    input  logic       skip,
`endif
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [4:0] level,
    output logic       busy,
    output logic       done
);

    localparam int MAXF = (STEP_FRAMES > HOLD_FRAMES) ?
                          STEP_FRAMES : HOLD_FRAMES;
    localparam int CW = (MAXF < 2) ? 1 : $clog2(MAXF);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_FRAMES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FADE_IN,
        HOLD,
        FADE_OUT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] frm_cnt;
    logic          skip_req;

`ifdef INTRO_FADE_SKIP_EN
    assign skip_req = skip;
`else
    assign skip_req = 1'b0;
`endif

    // (c*level)>>4 with a 9-bit product; level 16 passes c unchanged
    function automatic logic [3:0] scale(input logic [3:0] c,
                                         input logic [4:0] l);
        return 4'((9'(c) * 9'(l)) >> 4);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            frm_cnt <= '0;
            level   <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            red     <= 4'd0;
            green   <= 4'd0;
            blue    <= 4'd0;
        end else begin
            done  <= 1'b0;
            red   <= video_on ? scale(pal_red, level) : 4'd0;
            green <= video_on ? scale(pal_green, level) : 4'd0;
            blue  <= video_on ? scale(pal_blue, level) : 4'd0;

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= FADE_IN;
                        level   <= 5'd0;
                        frm_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                FADE_IN: begin
                    if (skip_req) begin
                        frm_cnt <= '0;
                        // nothing to fade out from level 0
                        if (level == 5'd0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= FADE_OUT;
                        end
                    end else if (frame_tick) begin
                        if (frm_cnt == STEP_LAST) begin
                            frm_cnt <= '0;
                            level   <= level + 5'd1;
                            if (level == 5'd15)
                                state <= HOLD;
                        end else begin
                            frm_cnt <= frm_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (skip_req) begin
                        state   <= FADE_OUT;
                        frm_cnt <= '0;
                    end else if (frame_tick) begin
                        if (frm_cnt == HOLD_LAST) begin
                            state   <= FADE_OUT;
                            frm_cnt <= '0;
                        end else begin
                            frm_cnt <= frm_cnt + 1'b1;
                        end
                    end
                end
                FADE_OUT: begin
                    if (frame_tick) begin
                        if (frm_cnt == STEP_LAST) begin
                            frm_cnt <= '0;
                            level   <= level - 5'd1;
                            if (level == 5'd1) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            frm_cnt <= frm_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intro_fade_ctrl.sv
// Scoreboard bench for intro_fade_ctrl (STEP=2/HOLD=3 and STEP=4 instances).
// Skip scenario is exercised when INTRO_FADE_SKIP_EN is defined.
module tb_intro_fade_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic       video_on = 1'b0;
    logic       skip = 1'b0;
    logic [3:0] pal_red = 4'd0;
    logic [3:0] pal_green = 4'd0;
    logic [3:0] pal_blue = 4'd0;

    logic [3:0] red, green, blue;
    logic [4:0] level;
    logic       busy, done;

    logic [3:0] red4, green4, blue4;
    logic [4:0] level4;
    logic       busy4, done4;

    int vectors = 0;
    int miscompares = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    intro_fade_ctrl #(.STEP_FRAMES(2), .HOLD_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .start(start),
        .frame_tick(frame_tick), .video_on(video_on),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
`ifdef INTRO_FADE_SKIP_EN
        .skip(skip),
`endif
        .red(red), .green(green), .blue(blue),
        .level(level), .busy(busy), .done(done)
    );

    intro_fade_ctrl #(.STEP_FRAMES(4), .HOLD_FRAMES(120)) dut4 (
        .clk(clk), .reset(reset), .start(start),
        .frame_tick(frame_tick), .video_on(video_on),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
`ifdef INTRO_FADE_SKIP_EN
        .skip(skip),
`endif
        .red(red4), .green(green4), .blue(blue4),
        .level(level4), .busy(busy4), .done(done4)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time expired, want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] ref_scale(input int c, input int l);
        int p;
        p = c * l;
        return 4'(p / 16);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // drive one pixel, queue its expected colour, pop it one clock later
    task automatic drive_pix(input logic [3:0] r, input logic [3:0] g,
                             input logic [3:0] b, input logic vo,
                             input int lvl);
        logic [11:0] e, got;
        pal_red = r;
        pal_green = g;
        pal_blue = b;
        video_on = vo;
        if (vo)
            exp_q.push_back({ref_scale(r, lvl), ref_scale(g, lvl),
                             ref_scale(b, lvl)});
        else
            exp_q.push_back(12'h000);
        step();
        e = exp_q.pop_front();
        got = {red, green, blue};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL rgb_lvl%0d: got %h want %h", lvl, got, e);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (level !== 5'd0) begin
            miscompares++;
            $display("FAIL rst_level: got %0d want 0", level);
        end
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_flags: got %b want 00", {busy, done});
        end
        vectors++;
        if ({red, green, blue} !== 12'h000) begin
            miscompares++;
            $display("FAIL rst_rgb: got %h want 000", {red, green, blue});
        end
        kick();
        ticks(14);
        vectors++;
        if (level !== 5'd7) begin
            miscompares++;
            $display("FAIL mid_level: got %0d want 7", level);
        end
        drive_pix(4'hC, 4'h1, 4'hE, 1'b1, 7);
        reset = 1'b1;
        step();
        vectors++;
        if ({level, busy, red, green, blue} !== 18'd0) begin
            miscompares++;
            $display("FAIL abort: lvl %0d busy %b rgb %h want 0/0/000",
                     level, busy, {red, green, blue});
        end
        step();
        reset = 1'b0;
        ticks(4);
        vectors++;
        if ({level, busy} !== 6'd0) begin
            miscompares++;
            $display("FAIL idle_after_rst: lvl %0d busy %b want 0/0",
                     level, busy);
        end
    endtask

    task automatic test_full_run();
        do_reset();
        kick();
        vectors++;
        if ({level, busy} !== {5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL run_start: lvl %0d busy %b want 0/1", level, busy);
        end
        ticks(32);
        vectors++;
        if ({level, busy} !== {5'd16, 1'b1}) begin
            miscompares++;
            $display("FAIL run_full: lvl %0d busy %b want 16/1", level, busy);
        end
        ticks(3);
        vectors++;
        if ({level, busy} !== {5'd16, 1'b1}) begin
            miscompares++;
            $display("FAIL run_hold: lvl %0d busy %b want 16/1", level, busy);
        end
        ticks(2);
        vectors++;
        if (level !== 5'd15) begin
            miscompares++;
            $display("FAIL run_out1: got %0d want 15", level);
        end
        ticks(29);
        vectors++;
        if ({level, busy, done} !== {5'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL run_pre_done: lvl %0d busy %b done %b want 1/1/0",
                     level, busy, done);
        end
        ticks(1);
        vectors++;
        if ({level, busy, done} !== {5'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL run_done: lvl %0d busy %b done %b want 0/0/1",
                     level, busy, done);
        end
        step();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got %b want 0", done);
        end
        ticks(5);
        vectors++;
        if ({level, busy, done} !== 7'd0) begin
            miscompares++;
            $display("FAIL done_hold: lvl %0d busy %b done %b want 0/0/0",
                     level, busy, done);
        end
    endtask

    task automatic test_scaling();
        do_reset();
        kick();
        for (int lv = 0; lv < 16; lv++) begin
            drive_pix(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'b1, lv);
            if (lv == 1)
                drive_pix(4'hF, 4'hF, 4'hF, 1'b1, 1);
            if (lv == 8)
                drive_pix(4'hC, 4'h1, 4'hE, 1'b1, 8);
            ticks(2);
        end
        drive_pix(4'hC, 4'h1, 4'hE, 1'b1, 16);
        for (int i = 0; i < 4; i++)
            drive_pix(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'b1, 16);
        drive_pix(4'hC, 4'h1, 4'hE, 1'b0, 16);
        pal_red = 4'h5;
        pal_green = 4'h5;
        pal_blue = 4'h5;
        video_on = 1'b1;
        #2;
        vectors++;
        if ({red, green, blue} !== 12'h000) begin
            miscompares++;
            $display("FAIL latency_early: got %h want 000", {red, green, blue});
        end
        step();
        vectors++;
        if ({red, green, blue} !== 12'h555) begin
            miscompares++;
            $display("FAIL latency_late: got %h want 555", {red, green, blue});
        end
    endtask

    task automatic test_collision();
        do_reset();
        start = 1'b1;
        frame_tick = 1'b1;
        step();
        start = 1'b0;
        frame_tick = 1'b0;
        ticks(1);
        vectors++;
        if ({level, busy} !== {5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL coll_tick: lvl %0d busy %b want 0/1", level, busy);
        end
        ticks(1);
        vectors++;
        if (level !== 5'd1) begin
            miscompares++;
            $display("FAIL coll_next: got %0d want 1", level);
        end
        ticks(30);
        ticks(1);
        kick();
        vectors++;
        if ({level, busy} !== {5'd16, 1'b1}) begin
            miscompares++;
            $display("FAIL hold_start: lvl %0d busy %b want 16/1", level, busy);
        end
        ticks(4);
        vectors++;
        if (level !== 5'd15) begin
            miscompares++;
            $display("FAIL hold_cont: got %0d want 15", level);
        end
    endtask

    task automatic test_pacing();
        do_reset();
        kick();
        for (int i = 1; i <= 8; i++) begin
            ticks(1);
            vectors++;
            if (level4 !== 5'(i / 4)) begin
                miscompares++;
                $display("FAIL pace_t%0d: got %0d want %0d",
                         i, level4, i / 4);
            end
        end
        repeat (100) step();
        vectors++;
        if ({level4, busy4} !== {5'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL pace_idle: lvl %0d busy %b want 2/1", level4, busy4);
        end
    endtask

`ifdef INTRO_FADE_SKIP_EN
    task automatic test_skip();
        do_reset();
        kick();
        ticks(18);
        skip = 1'b1;
        step();
        skip = 1'b0;
        vectors++;
        if ({level, busy} !== {5'd9, 1'b1}) begin
            miscompares++;
            $display("FAIL skip_entry: lvl %0d busy %b want 9/1", level, busy);
        end
        ticks(1);
        vectors++;
        if (level !== 5'd9) begin
            miscompares++;
            $display("FAIL skip_cnt_clr: got %0d want 9", level);
        end
        ticks(16);
        vectors++;
        if ({level, done} !== {5'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL skip_pre: lvl %0d done %b want 1/0", level, done);
        end
        ticks(1);
        vectors++;
        if ({level, busy, done} !== {5'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL skip_done: lvl %0d busy %b done %b want 0/0/1",
                     level, busy, done);
        end
        skip = 1'b1;
        start = 1'b1;
        step();
        skip = 1'b0;
        start = 1'b0;
        step();
        vectors++;
        if ({level, busy} !== {5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL skip_vs_start: lvl %0d busy %b want 0/1",
                     level, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_run();
        test_scaling();
        test_collision();
        test_pacing();
`ifdef INTRO_FADE_SKIP_EN
        test_skip();
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
